// File: rtl/pipelined_shift_unit_if.sv
// Valid/ready stream bundle for the pipelined shift unit: operand side (in_*)
// and result side (out_*). The unit itself connects through the slave modport.
interface pipelined_shift_unit_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             in_fill;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_bit;
    logic [1:0]       out_mode;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_data, out_bit, out_mode
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_data, out_bit, out_mode
    );
endinterface

// File: rtl/pipelined_shift_unit.sv
// Two-stage shift/rotate unit (SLL/SRL/SRA/ROL) with selectable fill and a
// shifted-out bit for link/carry. Operands register in s1, results in s2.
module pipelined_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_shift_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int ZW  = 2 * WIDTH + 1;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [SHW-1:0]   s1_amt_q,   s1_amt_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic             s1_fill_q,  s1_fill_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic             s2_bit_q,   s2_bit_d;
    logic [1:0]       s2_mode_q,  s2_mode_d;

    logic adv1, adv2;

    assign adv2        = !s2_valid_q | bus.out_ready;
    assign adv1        = !s1_valid_q | adv2;
    assign bus.in_ready = adv1;

    // Right shifts run through the same left shifter on a bit-reversed operand.
    // The shifter operates on {0, operand, filler}: the top bit collects the
    // last bit pushed out, and for ROL the filler is the operand itself.
    logic             is_right;
    logic             fill_bit;
    logic [WIDTH-1:0] lop;
    logic [WIDTH-1:0] res_l;
    logic [WIDTH-1:0] res_data;
    logic [ZW-1:0]    lvl [SHW+1];

    always_comb begin
        is_right = (s1_mode_q == MODE_SRL) || (s1_mode_q == MODE_SRA);
        fill_bit = (s1_mode_q == MODE_SRA) ? s1_data_q[WIDTH-1] : s1_fill_q;
        for (int i = 0; i < WIDTH; i++)
            lop[i] = is_right ? s1_data_q[WIDTH-1-i] : s1_data_q[i];
        lvl[0] = {1'b0, lop, (s1_mode_q == MODE_ROL) ? lop : {WIDTH{fill_bit}}};
        for (int k = 0; k < SHW; k++)
            lvl[k+1] = s1_amt_q[k] ? (lvl[k] << (1 << k)) : lvl[k];
        res_l = lvl[SHW][2*WIDTH-1:WIDTH];
        for (int i = 0; i < WIDTH; i++)
            res_data[i] = is_right ? res_l[WIDTH-1-i] : res_l[i];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_mode_d  = s1_mode_q;
        s1_fill_d  = s1_fill_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_bit_d   = s2_bit_q;
        s2_mode_d  = s2_mode_q;

        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = bus.in_data;
                s1_amt_d  = bus.in_amt;
                s1_mode_d = bus.in_mode;
                s1_fill_d = bus.in_fill;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res_data;
                s2_bit_d  = lvl[SHW][ZW-1];
                s2_mode_d = s1_mode_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s1_mode_q  <= MODE_SLL;
            s1_fill_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_bit_q   <= 1'b0;
            s2_mode_q  <= MODE_SLL;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_amt_q   <= s1_amt_d;
            s1_mode_q  <= s1_mode_d;
            s1_fill_q  <= s1_fill_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_bit_q   <= s2_bit_d;
            s2_mode_q  <= s2_mode_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_bit   = s2_bit_q;
    assign bus.out_mode  = s2_mode_q;
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Bench for pipelined_shift_unit (WIDTH=8): directed cases, streaming,
// back-pressure, mid-flight reset and random traffic against an arithmetic model.
module tb_pipelined_shift_unit;
    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic [1:0]   m;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errs   = 0;
    int   checks = 0;
    int   cyc    = 0;

    exp_t sb[$];
    int   outcyc[$];
    int   acccyc[$];

    logic         obs_in_ready, obs_valid;
    logic [W-1:0] obs_data;

    pipelined_shift_unit_if #(.WIDTH(W)) bus();

    pipelined_shift_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d, input int a, input logic [1:0] m,
                                   input logic f);
        exp_t        e;
        logic [63:0] x, mask, r;
        logic        fb;
        x    = 64'(d);
        mask = (64'd1 << W) - 1;
        fb   = (m == 2'b10) ? d[W-1] : f;
        case (m)
            2'b00:   r = (x << a) | (f ? ((64'd1 << a) - 1) : 64'd0);
            2'b11:   r = (x << a) | (x >> (W - a));
            default: r = (x >> a) | (fb ? (mask & ~(mask >> a)) : 64'd0);
        endcase
        r   = r & mask;
        e.d = r[W-1:0];
        e.m = m;
        if (a == 0)          e.b = 1'b0;
        else if (m == 2'b00) e.b = d[W-a];
        else if (m == 2'b11) e.b = r[0];
        else                 e.b = d[a-1];
        return e;
    endfunction

    // One bus cycle: drive, observe both handshakes, score, then cross the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [SHW-1:0] a,
                        input logic [1:0] m, input logic f, input logic ordy,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        bus.in_fill   = f;
        bus.out_ready = ordy;
        #1;
        obs_in_ready = bus.in_ready;
        obs_valid    = bus.out_valid;
        obs_data     = bus.out_data;
        acc = v & bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(bus.out_data), 64'(e.d));
                chk("sb_bit",  64'(bus.out_bit),  64'(e.b));
                chk("sb_mode", 64'(bus.out_mode), 64'(e.m));
                outcyc.push_back(cyc);
            end
        end
        if (acc) begin
            sb.push_back(model(d, int'(a), m, f));
            acccyc.push_back(cyc);
        end
        @(posedge clk);
    endtask

    task automatic single_op(input string tag, input logic [W-1:0] d, input logic [SHW-1:0] a,
                             input logic [1:0] m, input logic f,
                             input logic [W-1:0] xd, input logic xb);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        bus.in_fill   = f;
        bus.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_early_valid"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  64'(bus.out_data),  64'(xd));
        chk({tag, "_bit"},   64'(bus.out_bit),   64'(xb));
        chk({tag, "_mode"},  64'(bus.out_mode),  64'(m));
        @(posedge clk);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc);
        chk({tag, "_left"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] held;
        logic [W-1:0] pd;
        logic [SHW-1:0] pa;
        logic [1:0]   pm;
        logic         pf, pv;
        int           nacc;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0;
        bus.in_mode = 2'b00; bus.in_fill = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_bit",   64'(bus.out_bit),   64'd0);
        chk("rst_out_mode",  64'(bus.out_mode),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        single_op("sll",  8'h81, 3'd1, 2'b00, 1'b1, 8'h03, 1'b1);
        single_op("sra",  8'h90, 3'd3, 2'b10, 1'b0, 8'hF2, 1'b0);
        single_op("srl",  8'h90, 3'd3, 2'b01, 1'b0, 8'h12, 1'b0);
        single_op("rol",  8'hC3, 3'd2, 2'b11, 1'b0, 8'h0F, 1'b1);
        single_op("a0_sll", 8'h5A, 3'd0, 2'b00, 1'b1, 8'h5A, 1'b0);
        single_op("a0_srl", 8'h5A, 3'd0, 2'b01, 1'b1, 8'h5A, 1'b0);
        single_op("a0_sra", 8'h5A, 3'd0, 2'b10, 1'b0, 8'h5A, 1'b0);
        single_op("a0_rol", 8'h5A, 3'd0, 2'b11, 1'b0, 8'h5A, 1'b0);
        single_op("srl_fill", 8'h80, 3'd7, 2'b01, 1'b1, 8'hFF, 1'b0);
        single_op("sll_max", 8'h02, 3'd7, 2'b00, 1'b0, 8'h00, 1'b1);

        // Back-to-back stream of 8 with the sink always ready.
        outcyc.delete(); acccyc.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'($urandom), SHW'($urandom_range(0, W-1)), 2'($urandom),
                 1'($urandom), 1'b1, acc);
            chk("stream_in_ready", 64'(obs_in_ready), 64'd1);
        end
        drain("stream_drain");
        chk("stream_count", 64'(outcyc.size()), 64'd8);
        if (outcyc.size() == 8 && acccyc.size() == 8) begin
            chk("stream_consecutive", 64'(outcyc[7] - outcyc[0]), 64'd7);
            chk("stream_latency", 64'(outcyc[0] - acccyc[0]), 64'd2);
        end

        // Sink stalled for 5 cycles while the source keeps offering data.
        nacc = 0; held = '0;
        pd = W'($urandom); pa = SHW'($urandom_range(1, W-1)); pm = 2'($urandom); pf = 1'($urandom);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pd, pa, pm, pf, 1'b0, acc);
            if (acc) begin
                nacc++;
                pd = W'($urandom); pa = SHW'($urandom_range(0, W-1));
                pm = 2'($urandom); pf = 1'($urandom);
            end
            if (i == 2) held = obs_data;
            if (i >= 2) begin
                chk("bp_in_ready", 64'(obs_in_ready), 64'd0);
                chk("bp_out_valid", 64'(obs_valid), 64'd1);
                chk("bp_stable", 64'(obs_data), 64'(held));
            end
        end
        chk("bp_accepts", 64'(nacc), 64'd2);
        outcyc.delete();
        drain("bp_drain");
        chk("bp_drained", 64'(outcyc.size()), 64'd2);

        // Random traffic; a pending op is held until accepted.
        pv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pv && ($urandom_range(0, 3) != 0)) begin
                pv = 1'b1;
                pd = W'($urandom); pa = SHW'($urandom_range(0, W-1));
                pm = 2'($urandom); pf = 1'($urandom);
            end
            step(pv, pd, pa, pm, pf, 1'($urandom_range(0, 3) != 0), acc);
            if (acc) pv = 1'b0;
        end
        drain("rand_drain");

        // Reset with two ops in flight: nothing stale may come out.
        step(1'b1, 8'h11, 3'd1, 2'b00, 1'b0, 1'b0, acc);
        step(1'b1, 8'h22, 3'd2, 2'b11, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_data",  64'(bus.out_data),  64'd0);
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, acc);
            chk("mid_rst_no_stale", 64'(obs_valid), 64'd0);
        end
        single_op("post_rst", 8'hA5, 3'd4, 2'b10, 1'b0, 8'hFA, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
- Two-stage pipelined, parametrised shift/rotate unit with a valid/ready stream on both sides.
- Generalises the team's combinational left barrel shifter:
  - Four modes: logical left, logical right, arithmetic right, rotate left.
  - Selectable fill bit.
  - Shifted-out bit reported, for link/carry in the PDP-8 datapath (e.g. RAL/RTL).
- Sits between the operand-fetch stage and the accumulator write-back; absorbs back-pressure without losing data.

Parameters:
WIDTH, 32, data width in bits; must be a power of two, >= 2.
SHW, clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous and active-low.
in_valid  input  1  input transaction present.
in_ready  output  1  unit can accept input this cycle.
in_data  input  WIDTH  operand.
in_amt  input  SHW  shift distance, 0..WIDTH-1.
in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
in_fill  input  1  bit shifted into vacated positions for SLL/SRL; ignored for SRA/ROL.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result this cycle.
out_data  output  WIDTH  shift/rotate result.
out_bit  output  1  last bit shifted/rotated out.
out_mode  output  2  mode of the returned result, for sideband checking.

Behaviour:
- Reset:
  - Synchronous: rst_n low at a rising edge clears s1_valid, s2_valid and all data registers.
  - Outputs after reset: out_valid=0, out_data=0, out_bit=0, out_mode=0.
  - in_ready=1 one cycle after reset is released.
  - Reset mid-operation discards all in-flight transactions. Nothing is emitted after reset.
- Stage 1 (s1):
  - Registers in_data, in_amt, in_mode and in_fill on the handshake (in_valid & in_ready).
- Stage 2 (s2):
  - Holds the computed result; drives out_* directly from registers. No combinational path from in_* to out_*.
- Pipeline control:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1. in_ready depends only on state and out_ready, never on in_valid.
- Latency and throughput:
  - Accept at edge N; out_valid is high after edge N+1 if out_ready was not blocking.
  - Minimum latency is 2 edges from the in_* sample to the out_* update.
  - Throughput is 1 per cycle while out_ready=1.
- Stall: while out_valid & !out_ready, out_data, out_bit and out_mode hold stable. s1 may still fill once, then in_ready drops.
- Ordering: strictly in order. Nothing is dropped or duplicated.
- Arithmetic, with a = amount and d = data:
  - SLL: d << a; vacated low bits = in_fill; out_bit = d[WIDTH-a].
  - SRL: d >> a; vacated high bits = in_fill; out_bit = d[a-1].
  - SRA: d >> a; vacated high bits = d[WIDTH-1]; out_bit = d[a-1].
  - ROL: {d[WIDTH-1-a:0], d[WIDTH-1:WIDTH-a]}; out_bit = result[0] (bit that wrapped).
  - a = 0: out_data = d; out_bit = 0 in every mode.
- Implementation: log-structured, SHW mux levels, all between s1 and s2. Modes are implemented by bit-reversal around a left shifter or by per-level direction muxes. Either is acceptable if results match.
- Simultaneous events:
  - Output handshake and input handshake in the same cycle are both honoured; occupancy stays constant.
  - in_valid while in_ready=0: the input is not captured; the source must hold its data.

Test Plan:
- Reset, then WIDTH=8: SLL d=0x81, a=1, fill=1 -> out_data=0x03, out_bit=1, at 2 edges after accept.
- WIDTH=8 SRA d=0x90, a=3 -> 0xF2, out_bit=0. Same operand with SRL, fill=0 -> 0x12, out_bit=0.
- WIDTH=8 ROL d=0xC3, a=2 -> 0x0F, out_bit=1. Any mode with a=0, d=0x5A -> 0x5A, out_bit=0.
- Back-to-back stream of 8 ops with out_ready=1:
  - 8 results, in order, in 8 consecutive cycles after the first.
  - in_ready stays high throughout.
- Back-pressure: out_ready=0 for 5 cycles with a continuous input stream:
  - in_ready falls after 2 accepts.
  - out_data stays stable.
  - On release, both results drain in order with no loss.
- rst_n low for 1 cycle with 2 ops in flight:
  - out_valid=0 next cycle.
  - No stale result appears.
  - A fresh op afterwards returns its correct value with 2-edge latency.
